// File: rtl/tri_span_pkg.sv
// tri_span_pkg
// Shared types and constants for the triangle scanline span generator:
// FSM state encoding, Wishbone register word addresses, CTRL/STATUS bit
// positions and width helpers for the slope and accumulator datapaths.
package tri_span_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_WALK   = 2'd2,
        ST_FINISH = 2'd3
    } span_state_t;

    localparam logic [2:0] ADR_V0     = 3'd0;
    localparam logic [2:0] ADR_V1     = 3'd1;
    localparam logic [2:0] ADR_V2     = 3'd2;
    localparam logic [2:0] ADR_S02    = 3'd3;
    localparam logic [2:0] ADR_S01    = 3'd4;
    localparam logic [2:0] ADR_S12    = 3'd5;
    localparam logic [2:0] ADR_CTRL   = 3'd6;
    localparam logic [2:0] ADR_STATUS = 3'd7;

    localparam int CTRL_START  = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;
    localparam int STAT_CNT_LSB = 16;

    // Signed slope: integer part, fraction and a sign bit.
    function automatic int slope_w(input int coord_w, input int frac_w);
        return coord_w + frac_w + 1;
    endfunction

    // Accumulator: one extra bit over the slope so overshoot past the
    // right edge can still be told apart from negative values.
    function automatic int acc_w(input int coord_w, input int frac_w);
        return coord_w + frac_w + 2;
    endfunction

endpackage

// File: rtl/tri_edge_acc.sv
// tri_edge_acc
// Fixed-point edge walker for one triangle edge.
//   clk_sys, rst_b : clock, asynchronous active-low reset
//   load           : acc <= (load_x << FRAC_W) + load_slope/2, slope latched
//   step           : acc <= acc + latched slope (load has priority)
//   load_x         : starting x of the edge (integer pixels)
//   load_slope     : signed dx/dy in FRAC_W fractional bits
//   x_clamped      : integer part of acc clamped to [0, 2^COORD_W-1]
module tri_edge_acc
    import tri_span_pkg::*;
#(
    parameter int COORD_W = 8,
    parameter int FRAC_W  = 8
)
(
    input  logic                       clk_sys,
    input  logic                       rst_b,
    input  logic                       load,
    input  logic                       step,
    input  logic [COORD_W-1:0]         load_x,
    input  logic [COORD_W+FRAC_W:0]    load_slope,
    output logic [COORD_W-1:0]         x_clamped
);

    localparam int SLOPE_W = slope_w(COORD_W, FRAC_W);
    localparam int ACC_W   = acc_w(COORD_W, FRAC_W);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] slope_q;
    logic signed [ACC_W-1:0] slope_ext;
    logic signed [ACC_W-1:0] x_fix;
    logic signed [ACC_W-1:0] half_step;

    assign slope_ext = {load_slope[SLOPE_W-1], load_slope};
    assign x_fix     = {2'b00, load_x, {FRAC_W{1'b0}}};
    // Half a slope step moves the sample point to the pixel centre.
    assign half_step = slope_ext >>> 1;

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            acc     <= '0;
            slope_q <= '0;
        end else if (load) begin
            acc     <= x_fix + half_step;
            slope_q <= slope_ext;
        end else if (step) begin
            acc     <= acc + slope_q;
        end
    end

    // Top bit set: negative. Next bit set on a non-negative value: the
    // integer part is at least 2^COORD_W.
    always_comb begin
        x_clamped = acc[FRAC_W +: COORD_W];
        if (acc[ACC_W-1]) begin
            x_clamped = '0;
        end else if (acc[ACC_W-2]) begin
            x_clamped = '1;
        end
    end

endmodule

// File: rtl/tri_span_gen.sv
// tri_span_gen
// Triangle scanline span generator with a Wishbone classic register slave.
// Software loads three y-sorted vertices and three edge slopes, writes
// START, and the block emits one clamped {y, x_start, x_end} span per
// scanline from y0 to y2-1 on a valid/ready stream.
//
// Ports:
//   wb_clk_i, wb_rst_ni     : clock, asynchronous active-low reset
//   wbs_stb_i/cyc_i/we_i    : Wishbone classic strobe, cycle, write enable
//   wbs_sel_i, wbs_adr_i    : byte selects, word address [4:2]
//   wbs_dat_i / wbs_dat_o   : write / read data
//   wbs_ack_o               : registered acknowledge
//   span_valid/span_ready   : span stream handshake
//   span_y, span_x_start,
//   span_x_end              : scanline and inclusive ordered bounds
//   irq_o                   : done & IRQ_EN (only with TRI_SPAN_IRQ_EN)
//   busy                    : walk in progress
//
// Build option: define TRI_SPAN_IRQ_EN to add irq_o and a writable CTRL.IRQ_EN.
//
// state  | meaning
// IDLE   | waiting for START
// SETUP  | load edge accumulators, decide whether any line exists
// WALK   | present one span per line, advance on accept
// FINISH | set done, latch span count
module tri_span_gen
    import tri_span_pkg::*;
#(
    parameter int COORD_W = 8,
    parameter int FRAC_W  = 8
)
(
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic               wbs_stb_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [4:2]         wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    output logic               span_valid,
    input  logic               span_ready,
    output logic [COORD_W-1:0] span_y,
    output logic [COORD_W-1:0] span_x_start,
    output logic [COORD_W-1:0] span_x_end,
`ifdef TRI_SPAN_IRQ_EN
    output logic               irq_o,
`endif
    output logic               busy
);

    localparam int SLOPE_W = slope_w(COORD_W, FRAC_W);
    localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

    logic [31:0]        regs [0:5];
    span_state_t        state;
    logic [COORD_W-1:0] y_q;
    logic [15:0]        span_cnt;
    logic [15:0]        span_count;
    logic               done;
    logic               done_nxt;
    logic               irq_en;

    logic               bus_req;
    logic               wr_commit;
    logic               wr_ctrl;
    logic               abort_req;
    logic               start_req;
    logic               done_clr;
    logic [31:0]        rd_data;

    logic [COORD_W-1:0] x0, x1, y0, y1, y2;
    logic [SLOPE_W-1:0] s02, s01, s12;
    logic [COORD_W-1:0] y_nxt;
    logic               y_last;
    logic               accept;
    logic               load_l;
    logic               load_s;
    logic               use_short2;
    logic [COORD_W-1:0] xs_load;
    logic [SLOPE_W-1:0] ss_load;
    logic [COORD_W-1:0] x_long;
    logic [COORD_W-1:0] x_short;

    // ------------------------------------------------------------------
    // Bus: ack one cycle after the request; writes take effect at the end
    // of the ack cycle, so START seen in cycle N moves the FSM at N+1.
    // ------------------------------------------------------------------
    assign bus_req   = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
    assign wr_commit = wbs_stb_i & wbs_cyc_i & wbs_we_i & wbs_ack_o;
    assign wr_ctrl   = wr_commit & (wbs_adr_i == ADR_CTRL) & wbs_sel_i[0];
    assign abort_req = wr_ctrl & wbs_dat_i[CTRL_ABORT];
    assign start_req = wr_ctrl & wbs_dat_i[CTRL_START] & ~abort_req & ~busy;
    assign done_clr  = wr_commit & (wbs_adr_i == ADR_STATUS) & wbs_sel_i[0]
                     & wbs_dat_i[STAT_DONE];

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            for (int i = 0; i < 6; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_commit && !busy && (wbs_adr_i <= ADR_S12)) begin
            for (int b = 0; b < 4; b++) begin
                if (wbs_sel_i[b]) begin
                    regs[wbs_adr_i][8*b +: 8] <= wbs_dat_i[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (wbs_adr_i)
            ADR_CTRL:   rd_data[CTRL_IRQ_EN] = irq_en;
            ADR_STATUS: rd_data = {span_count, 14'd0, done, busy};
            default:    rd_data = regs[wbs_adr_i];
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= bus_req;
            wbs_dat_o <= (bus_req && !wbs_we_i) ? rd_data : '0;
        end
    end

    // ------------------------------------------------------------------
    // Done flag and optional interrupt
    // ------------------------------------------------------------------
    always_comb begin
        done_nxt = done;
        if (done_clr) begin
            done_nxt = 1'b0;
        end
        if (state == ST_FINISH && !abort_req) begin
            done_nxt = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            done <= 1'b0;
        end else begin
            done <= done_nxt;
        end
    end

`ifdef TRI_SPAN_IRQ_EN
    logic irq_en_nxt;

    assign irq_en_nxt = wr_ctrl ? wbs_dat_i[CTRL_IRQ_EN] : irq_en;

    // irq follows the next-state of done so it rises together with done.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            irq_en <= 1'b0;
            irq_o  <= 1'b0;
        end else begin
            irq_en <= irq_en_nxt;
            irq_o  <= done_nxt & irq_en_nxt;
        end
    end
`else
    assign irq_en = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Geometry fields
    // ------------------------------------------------------------------
    assign x0  = regs[ADR_V0][0 +: COORD_W];
    assign y0  = regs[ADR_V0][16 +: COORD_W];
    assign x1  = regs[ADR_V1][0 +: COORD_W];
    assign y1  = regs[ADR_V1][16 +: COORD_W];
    assign y2  = regs[ADR_V2][16 +: COORD_W];
    assign s02 = regs[ADR_S02][SLOPE_W-1:0];
    assign s01 = regs[ADR_S01][SLOPE_W-1:0];
    assign s12 = regs[ADR_S12][SLOPE_W-1:0];

    assign accept = span_valid & span_ready;
    assign y_nxt  = y_q + ONE;
    assign y_last = (y_q == (y2 - ONE));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            span_valid <= 1'b0;
            y_q        <= '0;
            span_cnt   <= '0;
            span_count <= '0;
        end else if (abort_req) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            span_valid <= 1'b0;
            span_count <= span_cnt + {15'd0, accept};
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        state    <= ST_SETUP;
                        busy     <= 1'b1;
                        span_cnt <= '0;
                    end
                end
                ST_SETUP: begin
                    y_q <= y0;
                    if (y0 == y2) begin
                        state <= ST_FINISH;
                    end else begin
                        state      <= ST_WALK;
                        span_valid <= 1'b1;
                    end
                end
                ST_WALK: begin
                    if (accept) begin
                        span_cnt <= span_cnt + 16'd1;
                        if (y_last) begin
                            state      <= ST_FINISH;
                            span_valid <= 1'b0;
                        end else begin
                            y_q <= y_nxt;
                        end
                    end
                end
                ST_FINISH: begin
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    span_count <= span_cnt;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Edge accumulators. The short edge switches to V1->V2 when the line
    // about to be presented is y1; with y0 == y1 that is the first line.
    // ------------------------------------------------------------------
    assign load_l     = (state == ST_SETUP);
    assign use_short2 = (state == ST_SETUP) ? (y0 == y1) : 1'b1;
    assign load_s     = (state == ST_SETUP) | (accept & (y_nxt == y1));
    assign xs_load    = use_short2 ? x1  : x0;
    assign ss_load    = use_short2 ? s12 : s01;

    tri_edge_acc #(
        .COORD_W    (COORD_W),
        .FRAC_W     (FRAC_W)
    ) u_edge_long (
        .clk_sys    (wb_clk_i),
        .rst_b      (wb_rst_ni),
        .load       (load_l),
        .step       (accept),
        .load_x     (x0),
        .load_slope (s02),
        .x_clamped  (x_long)
    );

    tri_edge_acc #(
        .COORD_W    (COORD_W),
        .FRAC_W     (FRAC_W)
    ) u_edge_short (
        .clk_sys    (wb_clk_i),
        .rst_b      (wb_rst_ni),
        .load       (load_s),
        .step       (accept),
        .load_x     (xs_load),
        .load_slope (ss_load),
        .x_clamped  (x_short)
    );

    // ------------------------------------------------------------------
    // Span outputs: ordered bounds of the two clamped edges.
    // ------------------------------------------------------------------
    assign span_y = y_q;

    always_comb begin
        if (x_long <= x_short) begin
            span_x_start = x_long;
            span_x_end   = x_short;
        end else begin
            span_x_start = x_short;
            span_x_end   = x_long;
        end
    end

endmodule

// File: tb/tb_tri_span_gen.sv
// Testbench for tri_span_gen: table-driven triangle walks plus directed
// sequences for abort, write protection, START/ABORT collision and reset.
module tb_tri_span_gen;

    localparam int COORD_W = 8;
    localparam int FRAC_W  = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [2:0]  adr = 3'd0;
    logic [31:0] dat_w = '0;
    logic        ack;
    logic [31:0] dat_r;
    logic        span_valid;
    logic        span_ready = 1'b1;
    logic [7:0]  span_y, span_xs, span_xe;
    logic        busy;
`ifdef TRI_SPAN_IRQ_EN
    logic        irq;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tri_span_gen #(.COORD_W(COORD_W), .FRAC_W(FRAC_W)) dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (rst_n),
        .wbs_stb_i    (stb),
        .wbs_cyc_i    (cyc),
        .wbs_we_i     (we),
        .wbs_sel_i    (sel),
        .wbs_adr_i    (adr),
        .wbs_dat_i    (dat_w),
        .wbs_ack_o    (ack),
        .wbs_dat_o    (dat_r),
        .span_valid   (span_valid),
        .span_ready   (span_ready),
        .span_y       (span_y),
        .span_x_start (span_xs),
        .span_x_end   (span_xe),
`ifdef TRI_SPAN_IRQ_EN
        .irq_o        (irq),
`endif
        .busy         (busy)
    );

    typedef struct {
        logic [31:0]       v0, v1, v2, s02, s01, s12;
        int                n;
        int                stall_y;
        int                stall_len;
        logic [5:0][23:0]  sp;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    function automatic logic [23:0] S(input int y, input int xs, input int xe);
        return {8'(y), 8'(xs), 8'(xe)};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic w, input logic [2:0] a, input logic [31:0] d,
                           output logic [31:0] rd);
        int n;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_w = d; sel = 4'hF;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 8);
        rd = dat_r;
        check("wb_ack", {31'd0, ack}, 32'd1);
        @(posedge clk);
        #1;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        wb_xfer(1'b1, a, d, dummy);
    endtask

    task automatic wb_read(input logic [2:0] a, output logic [31:0] rd);
        wb_xfer(1'b0, a, 32'd0, rd);
    endtask

    task automatic load_regs(input int t);
        wb_write(3'd0, vecs[t].v0);
        wb_write(3'd1, vecs[t].v1);
        wb_write(3'd2, vecs[t].v2);
        wb_write(3'd3, vecs[t].s02);
        wb_write(3'd4, vecs[t].s01);
        wb_write(3'd5, vecs[t].s12);
    endtask

    // Called just after the START write commits (first cycle of SETUP).
    task automatic run_walk(input int t);
        int got, cycles, busy_cyc, stall;
        logic [23:0] cur, snap;
        got = 0; cycles = 0; busy_cyc = 0; stall = 0; snap = '0;
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_no_valid", {31'd0, span_valid}, 32'd0);
        while (cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (!busy) break;
            busy_cyc++;
            if (span_valid) begin
                cur = {span_y, span_xs, span_xe};
                if (int'(span_y) == vecs[t].stall_y && stall < vecs[t].stall_len) begin
                    if (stall == 0) snap = cur;
                    else check("stall_hold", cur, snap);
                    span_ready = 1'b0;
                    stall++;
                end else begin
                    span_ready = 1'b1;
                    if (got < vecs[t].n) check($sformatf("v%0d_span%0d", t, got), cur, vecs[t].sp[got]);
                    else check("extra_span", got + 1, vecs[t].n);
                    got++;
                end
            end
        end
        span_ready = 1'b1;
        check("walk_timeout", {31'd0, busy}, 32'd0);
        check($sformatf("v%0d_span_count", t), got, vecs[t].n);
        check($sformatf("v%0d_busy_cycles", t), busy_cyc, vecs[t].n + 2 + vecs[t].stall_len);
    endtask

    function automatic vec_t mk(input logic [31:0] v0, v1, v2, s02, s01, s12,
                                input int n, input int sy, input int sl);
        vec_t v;
        v.v0 = v0; v.v1 = v1; v.v2 = v2;
        v.s02 = s02; v.s01 = s01; v.s12 = s12;
        v.n = n; v.stall_y = sy; v.stall_len = sl;
        v.sp = '0;
        return v;
    endfunction

    logic [31:0] rd;

    initial begin
        // Basic right triangle
        vecs[0] = mk(32'h0000_0000, 32'h0002_0000, 32'h0004_0004,
                     32'h100, 32'h0, 32'h200, 4, -1, 0);
        vecs[0].sp = {24'd0, 24'd0, S(3,3,3), S(2,1,2), S(1,0,1), S(0,0,0)};
        // Same with 3-cycle backpressure on y1
        vecs[1] = vecs[0];
        vecs[1].stall_y = 1; vecs[1].stall_len = 3;
        // Flat: y0 == y1 == y2
        vecs[2] = mk(32'h0005_000A, 32'h0005_0014, 32'h0005_0003,
                     32'h100, 32'h100, 32'h100, 0, -1, 0);
        // Clamp above 255
        vecs[3] = mk(32'h0000_00FA, 32'h0003_00FA, 32'h0006_00FA,
                     32'h400, 32'h0, 32'h0, 6, -1, 0);
        vecs[3].sp = {S(5,250,255), S(4,250,255), S(3,250,255),
                      S(2,250,255), S(1,250,255), S(0,250,252)};
        // Clamp below 0, long edge slope -2.0
        vecs[4] = mk(32'h0000_0002, 32'h0001_0002, 32'h0003_0002,
                     32'hFFFF_FE00, 32'h0, 32'h100, 3, -1, 0);
        vecs[4].sp = {24'd0, 24'd0, 24'd0, S(2,0,3), S(1,0,2), S(0,1,2)};
        // Flat top (y0 == y1): S01 must never be used
        vecs[5] = mk(32'h0000_0000, 32'h0000_0004, 32'h0002_0002,
                     32'h100, 32'hA00, 32'hFFFF_FF00, 2, -1, 0);
        vecs[5].sp = {24'd0, 24'd0, 24'd0, 24'd0, S(1,1,2), S(0,0,3)};
        // Flat bottom (y1 == y2): S12 must never be used
        vecs[6] = mk(32'h0000_0002, 32'h0002_0000, 32'h0002_0004,
                     32'h100, 32'hFFFF_FF00, 32'h500, 2, -1, 0);
        vecs[6].sp = {24'd0, 24'd0, 24'd0, 24'd0, S(1,0,3), S(0,1,2)};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", {31'd0, span_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_dat", dat_r, 32'd0);
        rst_n = 1'b1;
        wb_read(3'd7, rd);
        check("rst_status", rd, 32'd0);
        wb_read(3'd0, rd);
        check("rst_v0", rd, 32'd0);

        // Table-driven walks
        for (int t = 0; t < NV; t++) begin
            load_regs(t);
            wb_write(3'd7, 32'h2);
            span_ready = 1'b1;
            wb_write(3'd6, 32'h1);
            run_walk(t);
            wb_read(3'd7, rd);
            check($sformatf("v%0d_status", t), rd, (32'(vecs[t].n) << 16) | 32'h2);
        end

        // Abort and write protection
        load_regs(0);
        wb_write(3'd7, 32'h2);
        span_ready = 1'b0;
        wb_write(3'd6, 32'h1);
        wb_write(3'd0, 32'h0000_0007);
        wb_write(3'd6, 32'h1);
        check("ab_valid_held", {31'd0, span_valid}, 32'd1);
        check("ab_y_start", {24'd0, span_y}, 32'd0);
        @(negedge clk);
        span_ready = 1'b1;
        repeat (2) @(negedge clk);
        span_ready = 1'b0;
        check("ab_y_after2", {24'd0, span_y}, 32'd2);
        wb_write(3'd6, 32'h2);
        check("ab_valid_drop", {31'd0, span_valid}, 32'd0);
        check("ab_busy_drop", {31'd0, busy}, 32'd0);
        span_ready = 1'b1;
        wb_read(3'd7, rd);
        check("ab_status", rd, 32'h0002_0000);
        wb_read(3'd0, rd);
        check("ab_v0_protected", rd, 32'd0);

        // ABORT and START in the same word: ABORT wins
        wb_write(3'd6, 32'h3);
        check("ab_st_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("ab_st_busy2", {31'd0, busy}, 32'd0);
        check("ab_st_valid", {31'd0, span_valid}, 32'd0);

        // CTRL readback of IRQ_EN
        wb_write(3'd6, 32'h4);
        wb_read(3'd6, rd);
`ifdef TRI_SPAN_IRQ_EN
        check("ctrl_irq_en", rd, 32'h4);
        begin
            int n;
            wb_write(3'd6, 32'h5);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (busy && n < 50);
            check("irq_done_busy", {31'd0, busy}, 32'd0);
            check("irq_rise", {31'd0, irq}, 32'd1);
            wb_write(3'd7, 32'h2);
            check("irq_clear", {31'd0, irq}, 32'd0);
            wb_write(3'd6, 32'h0);
        end
`else
        check("ctrl_irq_en", rd, 32'h0);
`endif

        // Reset in the middle of a walk
        span_ready = 1'b1;
        wb_write(3'd6, 32'h1);
        repeat (3) @(negedge clk);
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mrst_valid", {31'd0, span_valid}, 32'd0);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wb_read(3'd7, rd);
        check("mrst_status", rd, 32'd0);
        wb_read(3'd2, rd);
        check("mrst_v2", rd, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
